// File: rtl/alu_test_sequencer.sv
// alu_test_sequencer: replays a small table of ALU test vectors, checks each response and tallies the results
//
// Optional feature macro: SEQ_FLAG_CHECK_EN
//   defined   -> a vector passes only if result and {SF, CF, ZF} all match the expected value
//   undefined -> only the result is compared; the flag inputs and expected flag bits are ignored
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   cfg_we/addr/vec/exp   vector table write port: vec = {a, b, op}, exp = {result, SF, CF, ZF}
//   start, num_vec        run request and vector count (saturated to DEPTH)
//   a, b, op, req         vector presented to the ALU
//   ack, result, SF/CF/ZF ALU response
//   busy, done            run in progress / run complete (held until the next start)
//   pass_cnt, fail_cnt    per-run tallies
//   first_fail, any_fail  index of the first failing vector and its valid flag
//   timeout               sticky: some vector of this run received no ack in time
module alu_test_sequencer #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8,
    parameter int TIMEOUT = 15,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [2*WIDTH+1:0]   cfg_vec,
    input  logic [WIDTH+2:0]     cfg_exp,
    input  logic                 start,
    input  logic [AW:0]          num_vec,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [1:0]           op,
    output logic                 req,
    input  logic                 ack,
    input  logic [WIDTH-1:0]     result,
    input  logic                 SF,
    input  logic                 CF,
    input  logic                 ZF,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          pass_cnt,
    output logic [AW:0]          fail_cnt,
    output logic [AW-1:0]        first_fail,
    output logic                 any_fail,
    output logic                 timeout
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FINISH} state_t;

    state_t               r_state, w_next;
    logic [2*WIDTH+1:0]   r_mem_vec [DEPTH];
    logic [WIDTH+2:0]     r_mem_exp [DEPTH];
    logic [AW-1:0]        r_idx;
    logic [AW:0]          r_n;
    logic [TW-1:0]        r_timer;
    logic [WIDTH-1:0]     r_res;
    logic [2:0]           r_flags;
    logic                 r_forced;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [1:0]           r_op;
    logic                 r_req, r_busy, r_done, r_any, r_to;
    logic [AW:0]          r_pass, r_fail;
    logic [AW-1:0]        r_ff;
    logic                 w_idle, w_go, w_last, w_expire, w_match, w_drive;
    logic [AW:0]          w_n_sat;
    logic [2*WIDTH+1:0]   w_vec;
    logic [WIDTH+2:0]     w_exp;

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_FINISH);
    assign w_go     = w_idle && start;
    assign w_n_sat  = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign w_last   = {1'b0, r_idx} == r_n - (AW+1)'(1);
    assign w_expire = r_timer == TW'(TIMEOUT - 1);
    assign w_vec    = r_mem_vec[r_idx];
    assign w_exp    = r_mem_exp[r_idx];
    assign w_drive  = (r_state == S_ISSUE) || (r_state == S_WAIT);

`ifdef SEQ_FLAG_CHECK_EN
    assign w_match = !r_forced && (r_res == w_exp[WIDTH+2:3]) && (r_flags == w_exp[2:0]);
`else
    logic w_unused_flags;
    assign w_match        = !r_forced && (r_res == w_exp[WIDTH+2:3]);
    assign w_unused_flags = ^{r_flags, w_exp[2:0]};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: if (start) w_next = (w_n_sat == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:          w_next = S_WAIT;
            S_WAIT:           if (ack || w_expire) w_next = S_CHECK;
            S_CHECK:          w_next = w_last ? S_FINISH : S_ISSUE;
            default:          w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Vector table has no reset so its contents survive a reset; writes only land between runs.
    always_ff @(posedge clk) begin
        if (reset && cfg_we && w_idle) begin
            r_mem_vec[cfg_addr] <= cfg_vec;
            r_mem_exp[cfg_addr] <= cfg_exp;
        end
    end

    // Outputs follow the current state one cycle later, so req becomes visible
    // in the first WAIT cycle and done rises one cycle after FINISH is entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_ff     <= '0;
            r_any    <= 1'b0;
            r_to     <= 1'b0;
            r_idx    <= '0;
            r_n      <= '0;
            r_timer  <= '0;
            r_res    <= '0;
            r_flags  <= '0;
            r_forced <= 1'b0;
        end else begin
            r_a    <= w_drive ? w_vec[2*WIDTH+1:WIDTH+2] : '0;
            r_b    <= w_drive ? w_vec[WIDTH+1:2] : '0;
            r_op   <= w_drive ? w_vec[1:0] : '0;
            r_req  <= w_drive;
            r_busy <= w_drive || (r_state == S_CHECK);
            r_done <= (r_state == S_FINISH) && !start;
            if (w_go) begin
                r_pass <= '0;
                r_fail <= '0;
                r_ff   <= '0;
                r_any  <= 1'b0;
                r_to   <= 1'b0;
                r_idx  <= '0;
                r_n    <= w_n_sat;
            end
            if (r_state == S_ISSUE) begin
                r_timer  <= '0;
                r_forced <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                if (ack) begin
                    r_res   <= result;
                    r_flags <= {SF, CF, ZF};
                end else if (w_expire) begin
                    r_forced <= 1'b1;
                    r_to     <= 1'b1;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
            if (r_state == S_CHECK) begin
                if (w_match) begin
                    r_pass <= r_pass + (AW+1)'(1);
                end else begin
                    r_fail <= r_fail + (AW+1)'(1);
                    if (!r_any) r_ff <= r_idx;
                    r_any <= 1'b1;
                end
                if (!w_last) r_idx <= r_idx + AW'(1);
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign op         = r_op;
    assign req        = r_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
    assign first_fail = r_ff;
    assign any_fail   = r_any;
    assign timeout    = r_to;
endmodule

// File: tb/tb_alu_test_sequencer.sv
// tb_alu_test_sequencer: directed scoreboard bench for alu_test_sequencer
module tb_alu_test_sequencer;
    localparam int WIDTH = 6;
    localparam int DEPTH = 8;
    localparam int TIMEOUT = 15;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [2*WIDTH+1:0] cfg_vec = '0;
    logic [WIDTH+2:0] cfg_exp = '0;
    logic start = 1'b0;
    logic [AW:0] num_vec = '0;
    logic ack = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic SF = 1'b0, CF = 1'b0, ZF = 1'b0;
    logic [WIDTH-1:0] a, b;
    logic [1:0] op;
    logic req, busy, done, any_fail, timeout;
    logic [AW:0] pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail;

    alu_test_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vec(cfg_vec),
        .cfg_exp(cfg_exp), .start(start), .num_vec(num_vec), .a(a), .b(b), .op(op), .req(req),
        .ack(ack), .result(result), .SF(SF), .CF(CF), .ZF(ZF), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail), .any_fail(any_fail),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pass_n; int fail_n; int ff; int anyf; int to; int lat; int pulses; int high;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [13:0] vecs [8] = '{14'b110011_101010_00, 14'b001010_000011_01, 14'b111100_001111_10,
                              14'b101010_101010_11, 14'b000101_001000_01, 14'b011111_000001_00,
                              14'b110000_000011_11, 14'b000000_111111_10};
    logic [8:0] exps [8] = '{9'b011101_010, 9'b000111_000, 9'b001100_000, 9'b000000_001,
                             9'b111101_110, 9'b100000_100, 9'b110011_100, 9'b000000_001};

    // ALU responder: 00 add, 01 sub (CF = borrow), 10 and, 11 xor
    logic ack_en = 1'b1;
    logic flip_cf = 1'b0;
    int ack_delay = 0;
    int hc = 0;

    function automatic logic [8:0] alu(input logic [5:0] x, input logic [5:0] y, input logic [1:0] o);
        logic [6:0] t;
        t = (o == 2'd0) ? {1'b0, x} + {1'b0, y} :
            (o == 2'd1) ? {1'b0, x} - {1'b0, y} :
            (o == 2'd2) ? {1'b0, x & y} : {1'b0, x ^ y};
        return {t[5:0], t[5], t[6], t[5:0] == 6'd0};
    endfunction

    always @(negedge clk) begin
        logic [8:0] r;
        hc = req ? hc + 1 : 0;
        r = alu(a, b, op);
        ack = req && ack_en && (hc > ack_delay);
        {result, SF, CF, ZF} = {r[8:3], r[2], r[1] ^ flip_cf, r[0]};
    end

    // Monitor and scoreboard
    logic rst_s = 1'b1, live = 1'b0, done_q = 1'b0, req_q = 1'b0, armed = 1'b0, fin = 1'b0;
    int cyc = 0, pulses = 0, high = 0;

    always @(posedge clk) begin
        rst_s <= reset;
        live <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [29:0] outs;
        outs = {a, b, op, req, busy, done, pass_cnt, fail_cnt, first_fail, any_fail, timeout};
        if (live) begin
            checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                errors++;
                $display("FAIL busy_done_exclusive got busy=1 done=1 expected not both");
            end
        end
        if (!rst_s) begin
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h expected 0", outs);
            end
            armed = 1'b0;
        end else if (armed) begin
            cyc++;
            if (req) high++;
            if (req && !req_q) pulses++;
            if (done && !done_q) begin
                armed = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got done with empty scoreboard expected none");
                end else begin
                    e = sb.pop_front();
                    chk("pass_cnt", int'(pass_cnt), e.pass_n);
                    chk("fail_cnt", int'(fail_cnt), e.fail_n);
                    chk("first_fail", int'(first_fail), e.ff);
                    chk("any_fail", int'(any_fail), e.anyf);
                    chk("timeout", int'(timeout), e.to);
                    chk("latency", cyc, e.lat);
                    chk("req_pulses", pulses, e.pulses);
                    chk("req_high_cycles", high, e.high);
                end
            end
        end
        if (start && !busy && rst_s) begin
            armed = 1'b1;
            cyc = -1;
            pulses = 0;
            high = 0;
        end
        done_q = done;
        req_q = req;
        if (fin) begin
            chk("scoreboard_empty", sb.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Stimulus
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int i, input logic [13:0] v, input logic [8:0] x);
        tick;
        cfg_we = 1'b1;
        cfg_addr = AW'(i);
        cfg_vec = v;
        cfg_exp = x;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic launch(input int n, input bit push, input exp_t e);
        if (push) sb.push_back(e);
        tick;
        start = 1'b1;
        num_vec = (AW+1)'(n);
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done;
        for (int i = 0; i < 2000 && !done; i++) tick;
        if (!done) begin
            $display("FAIL wait_done got no done expected done within 2000 cycles");
            $fatal(1, "done never asserted");
        end
        tick;
    endtask

    task automatic run(input int n, input exp_t e);
        launch(n, 1'b1, e);
        wait_done;
    endtask

    initial begin
        int rises;
        logic pq;
        repeat (3) tick;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) wr(i, vecs[i], exps[i]);
        run(1, '{1, 0, 0, 0, 0, 4, 1, 2});
        wr(1, vecs[1], 9'b000110_000);
        run(3, '{2, 1, 1, 1, 0, 10, 3, 6});
        wr(1, vecs[1], exps[1]);
        ack_delay = 4;
        launch(8, 1'b1, '{8, 0, 0, 0, 0, 57, 8, 48});
        repeat (10) tick;
        start = 1'b1;
        num_vec = 1;
        tick;
        start = 1'b0;
        wr(0, 14'h3fff, 9'h1ff);
        wait_done;
        ack_delay = 0;
        ack_en = 1'b0;
        run(2, '{0, 2, 0, 1, 1, 35, 2, 32});
        ack_en = 1'b1;
        run(1, '{1, 0, 0, 0, 0, 4, 1, 2});
        run(0, '{0, 0, 0, 0, 0, 1, 0, 0});
        run(12, '{8, 0, 0, 0, 0, 25, 8, 16});
        flip_cf = 1'b1;
`ifdef SEQ_FLAG_CHECK_EN
        run(1, '{0, 1, 0, 1, 0, 4, 1, 2});
`else
        run(1, '{1, 0, 0, 0, 0, 4, 1, 2});
`endif
        flip_cf = 1'b0;
        ack_delay = 5;
        launch(3, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0});
        rises = 0;
        pq = 1'b0;
        for (int i = 0; i < 500 && rises < 3; i++) begin
            tick;
            if (req && !pq) rises++;
            pq = req;
        end
        if (rises < 3) begin
            $display("FAIL vec2_wait got %0d req pulses expected 3", rises);
            $fatal(1, "third vector never issued");
        end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        ack_delay = 0;
        run(3, '{3, 0, 0, 0, 0, 10, 3, 6});
        tick;
        fin = 1'b1;
        repeat (5) tick;
    end
endmodule

// File: doc/alu_test_sequencer.md
ALU_TEST_SEQUENCER -- requirements
Module: alu_test_sequencer

Interface
REQ-001 Parameter WIDTH, 6, operand/result width in bits.
REQ-002 Parameter DEPTH, 8, vector memory entries (power of 2, >=2); AW = clog2(DEPTH).
REQ-003 Parameter TIMEOUT, 15, max WAIT cycles before a vector counts as failed (>=1).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cfg_we  in  1  vector memory write strobe.
REQ-007 cfg_addr  in  AW  vector write index.
REQ-008 cfg_vec  in  2*WIDTH+2  packed {a, b, op} for the written entry.
REQ-009 cfg_exp  in  WIDTH+3  packed {expected result, expected SF, CF, ZF}.
REQ-010 start  in  1  run request.
REQ-011 num_vec  in  AW+1  number of vectors to run.
REQ-012 a, b  out  WIDTH each  operands to ALU.
REQ-013 op  out  2  ALU opcode.
REQ-014 req  out  1  vector valid toward ALU.
REQ-015 ack  in  1  ALU result valid.
REQ-016 result  in  WIDTH  ALU result.
REQ-017 SF, CF, ZF  in  1 each  ALU flags.
REQ-018 busy  out  1  run in progress.
REQ-019 done  out  1  run complete, held until next start.
REQ-020 pass_cnt, fail_cnt  out  AW+1 each  vector tallies.
REQ-021 first_fail  out  AW  index of first failing vector; any_fail  out  1  at least one failure.
REQ-022 timeout  out  1  sticky, any vector timed out this run.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, CHECK, FINISH; every output is registered.
REQ-024 IDLE/FINISH: start=1 clears counters, first_fail, any_fail, timeout and idx, then -> ISSUE; start=1 with num_vec=0 -> FINISH with zero counts.
REQ-025 num_vec > DEPTH is saturated to DEPTH.
REQ-026 ISSUE (1 cycle): a/b/op = mem[idx], req=1, timer=0 -> WAIT.
REQ-027 WAIT: req held high, a/b/op held stable; ack=1 -> capture result and flags -> CHECK; otherwise timer+1, and timer == TIMEOUT-1 -> CHECK with forced mismatch and timeout set.
REQ-028 ack is ignored outside WAIT.
REQ-029 CHECK: match -> pass_cnt+1, else fail_cnt+1; first failure of the run loads first_fail=idx and sets any_fail; idx == n-1 -> FINISH, else idx+1 -> ISSUE.
REQ-030 a, b, op and req are zero in IDLE, CHECK and FINISH.
REQ-031 busy=1 in ISSUE/WAIT/CHECK; done=1 only in FINISH; never both.
REQ-032 Latency: with ack high in the first WAIT cycle, each vector takes 3 cycles and done rises 3N+1 cycles after start is sampled.
REQ-033 start while busy is ignored; cfg_we while busy is ignored (memory unchanged).
REQ-034 Memory contents survive reset and are undefined until written.

Reset
REQ-035 reset=0 at a clock edge forces IDLE, zeroes all outputs and counters, and cancels any run in progress (req drops the next cycle).
REQ-036 reset has priority over start, ack and cfg_we.

Configuration
REQ-037 With SEQ_FLAG_CHECK_EN defined: match = result and {SF, CF, ZF} all equal expected. Without it: match = result only; flag bits of cfg_exp and the SF/CF/ZF inputs are ignored.

Verification
REQ-038 WIDTH=6: vec0 a=110011 b=101010 op=00 exp=011101, num_vec=1, ack immediate -> done after 4 cycles, pass_cnt=1, fail_cnt=0, any_fail=0.
REQ-039 3 vectors, vec1 exp wrong -> pass_cnt=2, fail_cnt=1, first_fail=1, any_fail=1.
REQ-040 ack never asserted, TIMEOUT=15, num_vec=2 -> fail_cnt=2, timeout=1, req high exactly 16 cycles per vector (ISSUE + 15 WAIT).
REQ-041 reset=0 during WAIT of vec2 -> next cycle IDLE, req=0, counts 0; start after release reruns from idx 0.
REQ-042 SEQ_FLAG_CHECK_EN defined: result correct, CF mismatched -> fail_cnt=1; same stimulus with the macro undefined -> pass_cnt=1.
REQ-043 num_vec=0 -> FINISH next cycle, counts 0; num_vec=12 with DEPTH=8 -> exactly 8 req pulses.
